// File: rtl/iod_train_pkg.sv
// Shared types for the IOD receive-interface training sequencer:
// sequencer state encoding and FAIL_STEP encoding helpers.
package iod_train_pkg;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_LOCK_WAIT  = 3'd1,
        ST_CLK_TRAIN  = 3'd2,
        ST_RETRY      = 3'd3,
        ST_LANE_TRAIN = 3'd4,
        ST_LANE_NEXT  = 3'd5,
        ST_DONE       = 3'd6,
        ST_FAIL       = 3'd7
    } seq_state_e;

    localparam logic [4:0] FAIL_STEP_CLK = 5'd0;

    // Lane i is reported as step 1+i; step 0 is reserved for clock-align.
    function automatic logic [4:0] fail_step_lane(input logic [3:0] idx);
        return {1'b0, idx} + 5'd1;
    endfunction

endpackage

// File: rtl/iod_train_sequencer_if.sv
// Sequencer-facing bundle: PLL lock/retrain inputs, clock-align and per-lane
// trainer handshakes, and the interface-level status outputs.
interface iod_train_sequencer_if #(
    parameter int NUM_LANES = 4
);
    logic                 PLL_LOCK;
    logic                 RETRAIN;
    logic                 BCLKSCLK_TRAIN_START;
    logic                 BCLKSCLK_TRAIN_DONE;
    logic                 ICB_CLK_ALGN_ERR;
    logic                 CLK_ALGN_RSTRT;
    logic [NUM_LANES-1:0] LANE_TRAIN_START;
    logic [NUM_LANES-1:0] LANE_TRAIN_DONE;
    logic [NUM_LANES-1:0] LANE_TRAIN_ERR;
    logic                 TRAIN_DONE;
    logic                 TRAIN_FAIL;
    logic [4:0]           FAIL_STEP;
    logic [2:0]           SEQ_STATE;

    modport master (
        input  PLL_LOCK, RETRAIN, BCLKSCLK_TRAIN_DONE, ICB_CLK_ALGN_ERR,
               LANE_TRAIN_DONE, LANE_TRAIN_ERR,
        output BCLKSCLK_TRAIN_START, CLK_ALGN_RSTRT, LANE_TRAIN_START,
               TRAIN_DONE, TRAIN_FAIL, FAIL_STEP, SEQ_STATE
    );

    modport slave (
        output PLL_LOCK, RETRAIN, BCLKSCLK_TRAIN_DONE, ICB_CLK_ALGN_ERR,
               LANE_TRAIN_DONE, LANE_TRAIN_ERR,
        input  BCLKSCLK_TRAIN_START, CLK_ALGN_RSTRT, LANE_TRAIN_START,
               TRAIN_DONE, TRAIN_FAIL, FAIL_STEP, SEQ_STATE
    );
endinterface

// File: rtl/iod_train_timer.sv
// Clearable up-counter with an all-ones terminal-count flag; used for the
// lock-stable window and for the per-step timeout.
module iod_train_timer #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] base_s;

    // Clear and count may coincide, in which case the count restarts at one.
    always_comb begin
        base_s  = clr ? '0 : count_q;
        count_d = en ? base_s + WIDTH'(1) : base_s;
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = &count_q;

endmodule

// File: rtl/iod_train_sequencer.sv
// Training scheduler: lock-stable wait, clock-align, then each lane's
// bit-align in turn, with per-step timeout and bounded retries.
module iod_train_sequencer
    import iod_train_pkg::*;
#(
    parameter int NUM_LANES         = 4,
    parameter int LOCK_STABLE_WIDTH = 8,
    parameter int TIMEOUT_WIDTH     = 16,
    parameter int MAX_RETRY         = 3
) (
    input  logic                  SCLK,
    input  logic                  RESETN,
    iod_train_sequencer_if.master bus
);
    localparam logic [3:0] LAST_LANE   = 4'(NUM_LANES - 1);
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);

    seq_state_e           state_q, state_d;
    logic [3:0]           lane_idx_q, lane_idx_d;
    logic [2:0]           retry_q, retry_d;
    logic [4:0]           fail_step_q, fail_step_d;
    logic                 lane_phase_q, lane_phase_d;
    logic                 clk_start_q, clk_start_d;
    logic                 rstrt_q, rstrt_d;
    logic [NUM_LANES-1:0] lane_start_q, lane_start_d;
    logic                 done_q, done_d;
    logic                 fail_q, fail_d;

    logic                 lock_tc_s, step_tc_s;
    logic                 step_clr_s, step_en_s;
    logic                 lane_done_s, lane_err_s;
    logic [NUM_LANES-1:0] lane_onehot_s;

    iod_train_timer #(.WIDTH(LOCK_STABLE_WIDTH)) u_lock_timer (
        .clk   (SCLK),
        .rst_n (RESETN),
        .clr   (state_q == ST_IDLE),
        .en    ((state_q == ST_LOCK_WAIT) && bus.PLL_LOCK),
        .tc    (lock_tc_s)
    );

    // Restarts on every state change so each attempt sees a fresh window.
    assign step_clr_s = (state_d != state_q);
    assign step_en_s  = (state_d == ST_CLK_TRAIN) || (state_d == ST_LANE_TRAIN);

    iod_train_timer #(.WIDTH(TIMEOUT_WIDTH)) u_step_timer (
        .clk   (SCLK),
        .rst_n (RESETN),
        .clr   (step_clr_s),
        .en    (step_en_s),
        .tc    (step_tc_s)
    );

    // Select the active lane's done/error; other lanes are ignored.
    always_comb begin
        lane_done_s = 1'b0;
        lane_err_s  = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_done_s = lane_done_s | (bus.LANE_TRAIN_DONE[i] & (lane_idx_q == 4'(i)));
            lane_err_s  = lane_err_s  | (bus.LANE_TRAIN_ERR[i]  & (lane_idx_q == 4'(i)));
        end
    end

    // Next-state logic; outputs are derived from the next state so they
    // update together with the state register.
    always_comb begin
        state_d      = state_q;
        lane_idx_d   = lane_idx_q;
        retry_d      = retry_q;
        fail_step_d  = fail_step_q;
        lane_phase_d = lane_phase_q;
        if ((state_q != ST_IDLE) && !bus.PLL_LOCK) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.PLL_LOCK) begin
                        lane_idx_d   = 4'd0;
                        retry_d      = 3'd0;
                        lane_phase_d = 1'b0;
                        state_d      = ST_LOCK_WAIT;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOCK_WAIT: begin
                    state_d = lock_tc_s ? ST_CLK_TRAIN : ST_LOCK_WAIT;
                end
                ST_CLK_TRAIN: begin
                    if (bus.ICB_CLK_ALGN_ERR || step_tc_s) begin
                        state_d = ST_RETRY;
                    end else if (bus.BCLKSCLK_TRAIN_DONE) begin
                        retry_d      = 3'd0;
                        lane_idx_d   = 4'd0;
                        lane_phase_d = 1'b1;
                        state_d      = ST_LANE_TRAIN;
                    end else begin
                        state_d = ST_CLK_TRAIN;
                    end
                end
                ST_RETRY: begin
                    if (retry_q < RETRY_LIMIT) begin
                        retry_d = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
                        state_d = lane_phase_q ? ST_LANE_TRAIN : ST_CLK_TRAIN;
                    end else begin
                        fail_step_d = lane_phase_q ? fail_step_lane(lane_idx_q) : FAIL_STEP_CLK;
                        state_d     = ST_FAIL;
                    end
                end
                ST_LANE_TRAIN: begin
                    if (lane_err_s || step_tc_s) begin
                        state_d = ST_RETRY;
                    end else if (lane_done_s) begin
                        state_d = ST_LANE_NEXT;
                    end else begin
                        state_d = ST_LANE_TRAIN;
                    end
                end
                ST_LANE_NEXT: begin
                    if (lane_idx_q >= LAST_LANE) begin
                        state_d = ST_DONE;
                    end else begin
                        lane_idx_d = lane_idx_q + 4'd1;
                        retry_d    = 3'd0;
                        state_d    = ST_LANE_TRAIN;
                    end
                end
                ST_DONE: begin
                    state_d = bus.RETRAIN ? ST_IDLE : ST_DONE;
                end
                ST_FAIL: begin
                    state_d = bus.RETRAIN ? ST_IDLE : ST_FAIL;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        fail_step_d = (state_d == ST_IDLE) ? FAIL_STEP_CLK : fail_step_d;

        lane_onehot_s = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_onehot_s[i] = (lane_idx_d == 4'(i));
        end
        clk_start_d  = (state_d == ST_CLK_TRAIN);
        rstrt_d      = (state_d == ST_RETRY) && !lane_phase_q;
        lane_start_d = (state_d == ST_LANE_TRAIN) ? lane_onehot_s : '0;
        done_d       = (state_d == ST_DONE);
        fail_d       = (state_d == ST_FAIL);
    end

    // Sequencer state and registered outputs.
    always_ff @(posedge SCLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= ST_IDLE;
            lane_idx_q   <= 4'd0;
            retry_q      <= 3'd0;
            fail_step_q  <= 5'd0;
            lane_phase_q <= 1'b0;
            clk_start_q  <= 1'b0;
            rstrt_q      <= 1'b0;
            lane_start_q <= '0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            lane_idx_q   <= lane_idx_d;
            retry_q      <= retry_d;
            fail_step_q  <= fail_step_d;
            lane_phase_q <= lane_phase_d;
            clk_start_q  <= clk_start_d;
            rstrt_q      <= rstrt_d;
            lane_start_q <= lane_start_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.BCLKSCLK_TRAIN_START = clk_start_q;
    assign bus.CLK_ALGN_RSTRT       = rstrt_q;
    assign bus.LANE_TRAIN_START     = lane_start_q;
    assign bus.TRAIN_DONE           = done_q;
    assign bus.TRAIN_FAIL           = fail_q;
    assign bus.FAIL_STEP            = fail_step_q;
    assign bus.SEQ_STATE            = state_q;

endmodule

// File: doc/iod_train_sequencer.md
# iod_train_sequencer

Top-level training scheduler for one IOD receive interface. After PLL lock it runs the BCLK/SCLK clock-alignment trainer once, then runs each data lane's bit-align trainer one lane at a time. It enforces a per-step timeout and a bounded retry count, and reports interface-level done or fail. It sits between the fabric reset/PLL-lock logic and the CoreBclkSclkAlign and per-lane bit-align instances.

## Interface
- NUM_LANES, 4: number of bit-align lanes, 1..16.
- LOCK_STABLE_WIDTH, 8: lock must be stable for 2^W consecutive SCLK cycles.
- TIMEOUT_WIDTH, 16: per-step timeout of 2^W − 1 cycles.
- MAX_RETRY, 3: retries allowed per step after the first attempt, 0..7.

Ports:
- SCLK  in  1  system clock; the only clock.
- RESETN  in  1  asynchronous, active-low reset.
- PLL_LOCK  in  1  PLL lock, already synchronous to SCLK.
- RETRAIN  in  1  single-cycle request to rerun the full sequence; honoured only in DONE or FAIL.
- BCLKSCLK_TRAIN_START  out  1  level, held high for a clock-align attempt.
- BCLKSCLK_TRAIN_DONE  in  1  clock-align done (level).
- ICB_CLK_ALGN_ERR  in  1  clock-align error (level).
- CLK_ALGN_RSTRT  out  1  one-cycle restart pulse to the clock-align trainer.
- LANE_TRAIN_START  out  NUM_LANES  one-hot or zero; level per lane attempt.
- LANE_TRAIN_DONE  in  NUM_LANES  per-lane done.
- LANE_TRAIN_ERR  in  NUM_LANES  per-lane error.
- TRAIN_DONE  out  1  whole interface trained.
- TRAIN_FAIL  out  1  retries exhausted.
- FAIL_STEP  out  5  0 = clock-align, 1+i = lane i; valid while TRAIN_FAIL.
- SEQ_STATE  out  3  state encoding, for debug.

## Operation
States and encodings: IDLE 0, LOCK_WAIT 1, CLK_TRAIN 2, RETRY 3, LANE_TRAIN 4, LANE_NEXT 5, DONE 6, FAIL 7.

- **IDLE:** when PLL_LOCK=1, clear lane index, retry count and stable counter, then go to LOCK_WAIT.
- **LOCK_WAIT:** count cycles while PLL_LOCK=1. When the counter reaches all-ones, go to CLK_TRAIN.
- **CLK_TRAIN:** BCLKSCLK_TRAIN_START=1.
  - DONE=1 and ERR=0: clear retry count, go to LANE_TRAIN with lane 0.
  - ERR=1, or timeout: go to RETRY. ERR takes priority over DONE.
- **RETRY:** one cycle. All starts are 0.
  - If the failing step was clock-align, CLK_ALGN_RSTRT=1.
  - If retry count < MAX_RETRY: increment it and return to the failing step.
  - Otherwise go to FAIL and latch FAIL_STEP.
- **LANE_TRAIN:** LANE_TRAIN_START[idx]=1.
  - DONE[idx]=1 and ERR[idx]=0: go to LANE_NEXT.
  - ERR[idx] or timeout: go to RETRY.
  - Inputs from other lanes are ignored.
- **LANE_NEXT:** one cycle, START deasserted.
  - If idx = NUM_LANES−1, go to DONE.
  - Otherwise idx+1, clear retry count, go to LANE_TRAIN.
- **DONE:** TRAIN_DONE=1. RETRAIN goes to IDLE.
- **FAIL:** TRAIN_FAIL=1. RETRAIN goes to IDLE.

Global rules:
- PLL_LOCK=0 in any state except IDLE: next state is IDLE and all starts drop next cycle. This overrides every other transition.
- TRAIN_DONE and TRAIN_FAIL clear on the IDLE entry cycle.
- RETRAIN in any other state is ignored, not queued.
- Timeout counter: width TIMEOUT_WIDTH, cleared on every entry to CLK_TRAIN or LANE_TRAIN; it counts while in those states. Timeout fires when the counter reaches all-ones, and takes effect together with the ERR path.
- Retry counter: 3 bits, saturating. Lane index: 4 bits, never exceeds NUM_LANES−1.

## Timing
- All outputs are registered. The state change and output change happen in the same cycle as the state register update.
- Reset values:
  - state IDLE
  - BCLKSCLK_TRAIN_START 0
  - CLK_ALGN_RSTRT 0
  - LANE_TRAIN_START 0
  - TRAIN_DONE 0, TRAIN_FAIL 0
  - FAIL_STEP 0
  - SEQ_STATE 0
- Latency, lock rise to BCLKSCLK_TRAIN_START=1: 1 (IDLE) + 2^LOCK_STABLE_WIDTH (LOCK_WAIT) + 1 cycles.
- Latency, lane done to next lane START: 2 cycles, passing through LANE_NEXT.
- START is low for at least 1 cycle between consecutive attempts.
- CLK_ALGN_RSTRT is exactly 1 cycle wide.
- Asserting RESETN mid-sequence drops all outputs immediately.

## Structure
- Package iod_train_pkg holds the state enum/encoding and the FAIL_STEP encoding constants.
- One natural sub-module: iod_train_timer. It is a clearable up-counter with a terminal-count flag and is instantiated twice: lock-stable and step timeout.

## Test plan
- **Nominal:** NUM_LANES=4, LOCK_STABLE_WIDTH=3. Raise lock, then BCLKSCLK_TRAIN_DONE 20 cycles after start, and each lane done 10 cycles after its start.
  - START rises 10 cycles after lock.
  - Lanes start in order 0..3, each with a 1-cycle gap.
  - TRAIN_DONE=1; SEQ_STATE=6.
- **Clock-align error then success:** ICB_CLK_ALGN_ERR on the first attempt.
  - One CLK_ALGN_RSTRT pulse, START low 1 cycle, second attempt.
  - Success; retry count cleared before lane 0.
- **Lane 2 exhausted:** lane 2 never finishes, MAX_RETRY=3, TIMEOUT_WIDTH=4.
  - 4 attempts of 15 cycles each.
  - TRAIN_FAIL=1, FAIL_STEP=3, no CLK_ALGN_RSTRT pulses.
- **Lock loss mid-lane:** PLL_LOCK drops during lane 1 training.
  - The next cycle has SEQ_STATE=0 and all starts 0.
  - When lock returns, the full sequence reruns from clock-align.
- **Retrain:** RETRAIN in DONE returns to IDLE and reruns the sequence. RETRAIN pulsed during CLK_TRAIN has no effect.
- **Async reset during LANE_TRAIN:** all outputs are 0 within the reset cycle, and the sequence restarts at IDLE after release.
